// File: rtl/wb_dst_pipe_if.sv
// Bus bundle for the destination-register pipe.
// The ID-stage control is the master; the pipe is the slave.
interface wb_dst_pipe_if #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int DEPTH  = 3
);
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic                    in_valid;
  logic                    stall;
  logic                    flush;
  logic [WIDTH-1:0]        q_addr_a;
  logic [WIDTH-1:0]        q_addr_b;
  logic [WIDTH-1:0]        sel_addr;
  logic [DEPTH*WIDTH-1:0]  stage_addr;
  logic [DEPTH-1:0]        stage_valid;
  logic [DEPTH-1:0]        hit_a;
  logic [DEPTH-1:0]        hit_b;
  logic                    any_hit;

  modport master (
    output sel, in_bus, in_valid,
    output stall, flush,
    output q_addr_a, q_addr_b,
    input  sel_addr, stage_addr,
    input  stage_valid,
    input  hit_a, hit_b, any_hit
  );

  modport slave (
    input  sel, in_bus, in_valid,
    input  stall, flush,
    input  q_addr_a, q_addr_b,
    output sel_addr, stage_addr,
    output stage_valid,
    output hit_a, hit_b, any_hit
  );
endinterface

// File: rtl/wb_dst_pipe.sv
// Destination register select, carried down the pipe with
// valid bits; reports per-stage matches against two sources.
module wb_dst_pipe #(
  parameter int WIDTH     = 5,
  parameter int NUM_IN    = 4,
  parameter int SEL_W     = 2,
  parameter int DEPTH     = 3,
  parameter int ZERO_SKIP = 1
) (
  input  logic          clk,
  input  logic          rst,
  wb_dst_pipe_if.slave  bus
);

  generate
    if (NUM_IN > (1 << SEL_W)) begin : g_bad_sel
      $error("NUM_IN exceeds select range");
    end
  endgenerate

  logic [WIDTH-1:0] sel_addr;
  logic             new_v;
  logic             zs_a;
  logic             zs_b;

  logic [WIDTH-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0] addr_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;

  logic [DEPTH*WIDTH-1:0] st_addr;
  logic [DEPTH-1:0]       hit_a;
  logic [DEPTH-1:0]       hit_b;

  // Out-of-range selects fall through to address 0.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        sel_addr = bus.in_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  assign new_v = bus.in_valid &&
                 !((ZERO_SKIP != 0) && (sel_addr == '0));

  always_comb begin
    addr_d = addr_q;
    vld_d  = vld_q;
    if (bus.flush) begin
      addr_d[0] = '0;
      vld_d[0]  = 1'b0;
    end else if (!bus.stall) begin
      addr_d[0] = sel_addr;
      vld_d[0]  = new_v;
    end
    // A stall holds stage 0, so stage 1 must take a bubble.
    for (int k = 1; k < DEPTH; k++) begin
      if ((k == 1) && bus.stall) begin
        addr_d[k] = '0;
        vld_d[k]  = 1'b0;
      end else begin
        addr_d[k] = addr_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
      end
      vld_q <= '0;
    end else begin
      addr_q <= addr_d;
      vld_q  <= vld_d;
    end
  end

  assign zs_a = (ZERO_SKIP != 0) && (bus.q_addr_a == '0);
  assign zs_b = (ZERO_SKIP != 0) && (bus.q_addr_b == '0);

  always_comb begin
    st_addr = '0;
    hit_a   = '0;
    hit_b   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      st_addr[k*WIDTH +: WIDTH] = addr_q[k];
      hit_a[k] = vld_q[k] && !zs_a &&
                 (addr_q[k] == bus.q_addr_a);
      hit_b[k] = vld_q[k] && !zs_b &&
                 (addr_q[k] == bus.q_addr_b);
    end
  end

  assign bus.sel_addr    = sel_addr;
  assign bus.stage_addr  = st_addr;
  assign bus.stage_valid = vld_q;
  assign bus.hit_a       = hit_a;
  assign bus.hit_b       = hit_b;
  assign bus.any_hit     = (|hit_a) | (|hit_b);

endmodule

// File: tb/tb_wb_dst_pipe.sv
// Bench for wb_dst_pipe: directed table, corner sequences,
// then random traffic against a behavioural model.
module tb_wb_dst_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_dst_pipe_if #(.NUM_IN(4)) b4 ();
  wb_dst_pipe_if #(.NUM_IN(3)) b3 ();

  wb_dst_pipe #(.NUM_IN(4)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  wb_dst_pipe #(.NUM_IN(3)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [19:0] bus;
    logic [1:0]  sel;
    logic        iv;
    logic        st;
    logic        fl;
    logic [4:0]  qa;
    logic [4:0]  qb;
    logic [14:0] ea;
    logic [2:0]  ev;
    logic [2:0]  eha;
    logic [2:0]  ehb;
    logic        eany;
  } vec_t;

  localparam logic [19:0] CB = {5'd0, 5'd31, 5'd17, 5'd8};
  localparam logic [19:0] BB = {5'd9, 5'd7, 5'd6, 5'd5};
  localparam logic [19:0] DB = {5'd0, 5'd0, 5'd3, 5'd12};

  vec_t vt [15];

  // Reference model state: one {addr, valid} per stage.
  int ma [3];
  bit mv [3];

  function automatic logic [4:0] mmux(input logic [19:0] b,
                                      input logic [1:0] s);
    return 5'((b >> (int'(s) * 5)) & 20'h1f);
  endfunction

  function automatic logic [2:0] mhit(input logic [4:0] q);
    logic [2:0] h;
    h = '0;
    for (int k = 0; k < 3; k++)
      h[k] = mv[k] && (ma[k] == int'(q)) && (q != 0);
    return h;
  endfunction

  function automatic logic [14:0] mpack();
    return {5'(ma[2]), 5'(ma[1]), 5'(ma[0])};
  endfunction

  function automatic logic [2:0] mvld();
    return {mv[2], mv[1], mv[0]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    b4.sel = 2'd1;
    b4.in_bus = CB;
    b4.in_valid = 1'b1;
    b4.stall = 1'b0;
    b4.flush = 1'b0;
    b4.q_addr_a = '0;
    b4.q_addr_b = '0;
    b3.sel = 2'd3;
    b3.in_bus = {5'd31, 5'd17, 5'd8};
    b3.in_valid = 1'b1;
    b3.stall = 1'b0;
    b3.flush = 1'b0;
    b3.q_addr_a = '0;
    b3.q_addr_b = '0;

    // Reset held two edges with a valid entry offered.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_valid", 32'(b4.stage_valid), 0);
      chk("rst_addr", 32'(b4.stage_addr), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 32'(b4.stage_valid), 0);
    @(posedge clk);
    #1;
    chk("first_addr", 32'(b4.stage_addr[4:0]), 17);
    chk("first_valid", 32'(b4.stage_valid), 3'b001);

    // NUM_IN=3 instance: sel=3 is out of range.
    @(negedge clk);
    b3.sel = 2'd3;
    #1;
    chk("oor_sel_addr", 32'(b3.sel_addr), 0);
    @(posedge clk);
    #1;
    chk("oor_s0_valid", 32'(b3.stage_valid[0]), 0);
    chk("oor_s0_addr", 32'(b3.stage_addr[4:0]), 0);
    chk("oor_hit_a", 32'(b3.hit_a), 0);
    @(negedge clk);
    b3.sel = 2'd2;
    #1;
    chk("n3_sel2_addr", 32'(b3.sel_addr), 31);
    @(posedge clk);
    #1;
    chk("n3_sel2_valid", 32'(b3.stage_valid[0]), 1);
    @(negedge clk);
    b3.sel = 2'd3;
    b3.q_addr_a = 5'd31;
    #1;
    chk("n3_hit31", 32'(b3.hit_a), 3'b001);
    @(posedge clk);
    #1;
    chk("n3_zero_nohit", 32'(b3.hit_a[0]), 0);
    chk("n3_hit31_s1", 32'(b3.hit_a), 3'b010);

    vt[0]  = '{CB, 2'd1, 1'b1, 1'b0, 1'b0, 5'd17, 5'd0,
               {5'd0, 5'd0, 5'd17}, 3'b001, 3'b001, 3'b000, 1'b1};
    vt[1]  = '{CB, 2'd1, 1'b0, 1'b0, 1'b0, 5'd17, 5'd0,
               {5'd0, 5'd17, 5'd17}, 3'b010, 3'b010, 3'b000, 1'b1};
    vt[2]  = '{CB, 2'd1, 1'b0, 1'b0, 1'b0, 5'd17, 5'd0,
               {5'd17, 5'd17, 5'd17}, 3'b100, 3'b100, 3'b000, 1'b1};
    vt[3]  = '{CB, 2'd1, 1'b0, 1'b0, 1'b0, 5'd17, 5'd0,
               {5'd17, 5'd17, 5'd17}, 3'b000, 3'b000, 3'b000, 1'b0};
    vt[4]  = '{BB, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0,
               {5'd17, 5'd17, 5'd5}, 3'b001, 3'b000, 3'b000, 1'b0};
    vt[5]  = '{BB, 2'd1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0,
               {5'd17, 5'd5, 5'd6}, 3'b011, 3'b000, 3'b000, 1'b0};
    vt[6]  = '{BB, 2'd2, 1'b1, 1'b0, 1'b0, 5'd6, 5'd5,
               {5'd5, 5'd6, 5'd7}, 3'b111, 3'b010, 3'b100, 1'b1};
    vt[7]  = '{BB, 2'd3, 1'b1, 1'b1, 1'b0, 5'd6, 5'd5,
               {5'd6, 5'd0, 5'd7}, 3'b101, 3'b100, 3'b000, 1'b1};
    vt[8]  = '{BB, 2'd3, 1'b0, 1'b0, 1'b0, 5'd7, 5'd9,
               {5'd0, 5'd7, 5'd9}, 3'b010, 3'b010, 3'b000, 1'b1};
    vt[9]  = '{BB, 2'd3, 1'b1, 1'b0, 1'b0, 5'd9, 5'd7,
               {5'd7, 5'd9, 5'd9}, 3'b101, 3'b001, 3'b100, 1'b1};
    vt[10] = '{BB, 2'd0, 1'b1, 1'b1, 1'b1, 5'd9, 5'd7,
               {5'd9, 5'd0, 5'd0}, 3'b000, 3'b000, 3'b000, 1'b0};
    vt[11] = '{DB, 2'd1, 1'b0, 1'b0, 1'b0, 5'd12, 5'd3,
               {5'd0, 5'd0, 5'd3}, 3'b000, 3'b000, 3'b000, 1'b0};
    vt[12] = '{DB, 2'd0, 1'b1, 1'b0, 1'b0, 5'd12, 5'd3,
               {5'd0, 5'd3, 5'd12}, 3'b001, 3'b001, 3'b000, 1'b1};
    vt[13] = '{DB, 2'd0, 1'b1, 1'b0, 1'b0, 5'd12, 5'd3,
               {5'd3, 5'd12, 5'd12}, 3'b011, 3'b011, 3'b000, 1'b1};
    vt[14] = '{DB, 2'd0, 1'b1, 1'b0, 1'b1, 5'd4, 5'd3,
               {5'd12, 5'd12, 5'd0}, 3'b110, 3'b000, 3'b000, 1'b0};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rst = 1'b0;
      b4.in_bus = vt[i].bus;
      b4.sel = vt[i].sel;
      b4.in_valid = vt[i].iv;
      b4.stall = vt[i].st;
      b4.flush = vt[i].fl;
      b4.q_addr_a = vt[i].qa;
      b4.q_addr_b = vt[i].qb;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_addr", i), 32'(b4.stage_addr), 32'(vt[i].ea));
      chk($sformatf("v%0d_valid", i), 32'(b4.stage_valid), 32'(vt[i].ev));
      chk($sformatf("v%0d_hit_a", i), 32'(b4.hit_a), 32'(vt[i].eha));
      chk($sformatf("v%0d_hit_b", i), 32'(b4.hit_b), 32'(vt[i].ehb));
      chk($sformatf("v%0d_any", i), 32'(b4.any_hit), 32'(vt[i].eany));
    end

    // Random traffic against the model, with occasional reset.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ma[k] = 0;
      mv[k] = 1'b0;
    end
    for (int n = 0; n < 400; n++) begin
      logic [4:0] sa;
      bit nv;
      int na [3];
      bit nvv [3];
      @(negedge clk);
      rst = ($urandom_range(0, 39) == 0);
      b4.in_bus = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      b4.sel = 2'($urandom_range(0, 3));
      b4.in_valid = ($urandom_range(0, 3) != 0);
      b4.stall = ($urandom_range(0, 3) == 0);
      b4.flush = ($urandom_range(0, 5) == 0);
      b4.q_addr_a = 5'($urandom_range(0, 7));
      b4.q_addr_b = 5'($urandom_range(0, 7));
      #1;
      sa = mmux(b4.in_bus, b4.sel);
      nv = b4.in_valid && (sa != 0);
      chk("rnd_sel_addr", 32'(b4.sel_addr), 32'(sa));
      chk("rnd_hit_a", 32'(b4.hit_a), 32'(mhit(b4.q_addr_a)));
      chk("rnd_hit_b", 32'(b4.hit_b), 32'(mhit(b4.q_addr_b)));
      chk("rnd_any", 32'(b4.any_hit),
          32'(|{mhit(b4.q_addr_a), mhit(b4.q_addr_b)}));
      // Next model state from the pipe rules.
      na[2] = ma[1];
      nvv[2] = mv[1];
      na[1] = b4.stall ? 0 : ma[0];
      nvv[1] = b4.stall ? 1'b0 : mv[0];
      if (b4.flush) begin
        na[0] = 0;
        nvv[0] = 1'b0;
      end else if (b4.stall) begin
        na[0] = ma[0];
        nvv[0] = mv[0];
      end else begin
        na[0] = int'(sa);
        nvv[0] = nv;
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        ma[k] = rst ? 0 : na[k];
        mv[k] = rst ? 1'b0 : nvv[k];
      end
      #1;
      chk("rnd_stage_addr", 32'(b4.stage_addr), 32'(mpack()));
      chk("rnd_stage_valid", 32'(b4.stage_valid), 32'(mvld()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
